// File: rtl/mem_bank_param_pkg.sv
// ============================================================================
// mem_bank_param_pkg : shared state encodings, default geometry and CPU opcodes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package mem_bank_param_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int c_DEFAULT_DATA_W = 16;
    localparam int c_DEFAULT_DEPTH  = 16;

    // Opcode values shared with the control unit
    localparam logic [3:0] c_OP_NOP           = 4'h0;
    localparam logic [3:0] c_OP_ADD           = 4'h1;
    localparam logic [3:0] c_OP_SUB           = 4'h2;
    localparam logic [3:0] c_OP_MUL           = 4'h3;
    localparam logic [3:0] c_OP_DISPLAY_STORE = 4'h4;
    localparam logic [3:0] c_OP_CLEAR         = 4'h5;

endpackage

`default_nettype wire

// File: rtl/mem_clear_seq.sv
// ============================================================================
// mem_clear_seq : bulk-clear sequencer, one address per cycle, busy/done status
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_clear_seq
    import mem_bank_param_pkg::*;
#(
    parameter int  DEPTH          = c_DEFAULT_DEPTH,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ptr,
    output logic              active,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done;

    // Terminal count is an explicit compare, never a wrap of the pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            end else begin
                if (r_ptr == c_LAST) begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    assign ptr    = r_ptr;
    assign active = (r_state == ST_CLEAR);
    assign done   = r_done;

endmodule

`default_nettype wire

// File: rtl/mem_bank_param.sv
// ============================================================================
// mem_bank_param : 1W/2R data memory with registered reads, write-first bypass
//                  and a sequenced bulk clear
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_bank_param
    import mem_bank_param_pkg::*;
#(
    parameter int  DATA_W         = c_DEFAULT_DATA_W,
    parameter int  DEPTH          = c_DEFAULT_DEPTH,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              busy,
    output logic              clr_done
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    logic              r_rd_valid;
    logic              r_wr_done;

    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_busy;
    logic              w_clr_done;
    logic              w_clr_start;
    logic              w_wr_accept;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // A clear request in the same cycle as a write wins and drops the write
    assign w_clr_start = clr_req && !w_busy;
    assign w_wr_accept = wr_req && !w_busy && !clr_req;

    mem_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (w_clr_start),
        .ptr    (w_clr_ptr),
        .active (w_busy),
        .done   (w_clr_done)
    );

    // Storage has no reset; only the sweep zeroes it
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_ptr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_rd_a = (w_wr_accept && (rd_addr_a == wr_addr)) ? wr_data : r_mem[rd_addr_a];
    assign w_rd_b = (w_wr_accept && (rd_addr_b == wr_addr)) ? wr_data : r_mem[rd_addr_b];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_wr_done  <= w_wr_accept;
            if (rd_en) begin
                r_rd_data_a <= w_busy ? '0 : w_rd_a;
                r_rd_data_b <= w_busy ? '0 : w_rd_b;
            end
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;
    assign wr_done   = r_wr_done;
    assign busy      = w_busy;
    assign clr_done  = w_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_bank_param.sv
// ============================================================================
// tb_mem_bank_param : directed self-checking bench for mem_bank_param
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_bank_param;

    logic        clk;
    logic        rst;

    logic        wr_req, clr_req, rd_en;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid, wr_done, busy, clr_done;

    logic        wr_req_w, clr_req_w, rd_en_w;
    logic [5:0]  wr_addr_w, rd_addr_a_w, rd_addr_b_w;
    logic [31:0] wr_data_w;
    logic [31:0] rd_data_a_w, rd_data_b_w;
    logic        rd_valid_w, wr_done_w, busy_w, clr_done_w;

    int errors = 0;
    int checks = 0;

    mem_bank_param #(.DATA_W(16), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
        .wr_done(wr_done), .busy(busy), .clr_done(clr_done)
    );

    mem_bank_param #(.DATA_W(32), .DEPTH(64), .CLEAR_ON_RESET(1'b1)) u_dut_w (
        .clk(clk), .rst(rst), .wr_req(wr_req_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
        .clr_req(clr_req_w), .rd_en(rd_en_w), .rd_addr_a(rd_addr_a_w), .rd_addr_b(rd_addr_b_w),
        .rd_data_a(rd_data_a_w), .rd_data_b(rd_data_b_w), .rd_valid(rd_valid_w),
        .wr_done(wr_done_w), .busy(busy_w), .clr_done(clr_done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt16, cnt64, done16_at, done64_at, wr_during_busy, cnt;

        rst = 1'b1;
        wr_req = 0; clr_req = 0; rd_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
        wr_req_w = 0; clr_req_w = 0; rd_en_w = 0; wr_addr_w = 0; wr_data_w = 0;
        rd_addr_a_w = 0; rd_addr_b_w = 0;

        // ---- reset state and power-on sweep ----
        tick(); tick();
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data_a", rd_data_a, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_clr_done", clr_done, 0);
        rst = 1'b0;
        cnt16 = 0; cnt64 = 0; done16_at = -1; done64_at = -1;
        for (int i = 0; i < 80; i++) begin
            if (busy) cnt16++;
            if (busy_w) cnt64++;
            if (clr_done && done16_at < 0) done16_at = i;
            if (clr_done_w && done64_at < 0) done64_at = i;
            tick();
        end
        check("sweep16_busy_cycles", cnt16, 16);
        check("sweep16_done_cycle", done16_at, 16);
        check("sweep64_busy_cycles", cnt64, 64);
        check("sweep64_done_cycle", done64_at, 64);

        for (int i = 0; i < 16; i++) begin
            rd_en = 1; rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
            tick();
            check($sformatf("cleared_a[%0d]", i), rd_data_a, 0);
            check($sformatf("cleared_b[%0d]", 15 - i), rd_data_b, 0);
        end
        rd_en = 0;

        // ---- write then dual read of the same word ----
        wr_req = 1; wr_addr = 5; wr_data = 16'h1234;
        tick();
        check("wr5_done", wr_done, 1);
        wr_req = 0;
        tick();
        check("wr5_done_pulse", wr_done, 0);
        rd_en = 1; rd_addr_a = 5; rd_addr_b = 5;
        tick();
        check("rd5_valid", rd_valid, 1);
        check("rd5_a", rd_data_a, 16'h1234);
        check("rd5_b", rd_data_b, 16'h1234);
        rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
        tick();
        check("rd_valid_pulse", rd_valid, 0);
        check("rd_hold_a", rd_data_a, 16'h1234);

        // ---- bypass on both ports ----
        wr_req = 1; wr_addr = 4; wr_data = 16'h4444;
        tick();
        wr_addr = 3; wr_data = 16'hBEEF; rd_en = 1; rd_addr_a = 3; rd_addr_b = 4;
        tick();
        check("byp_a", rd_data_a, 16'hBEEF);
        check("byp_b_old", rd_data_b, 16'h4444);
        check("byp_wr_done", wr_done, 1);
        wr_addr = 6; wr_data = 16'h6666; rd_addr_a = 7; rd_addr_b = 6;
        tick();
        check("byp2_a_old", rd_data_a, 0);
        check("byp2_b", rd_data_b, 16'h6666);
        wr_req = 0; rd_en = 0;
        tick();

        // ---- clear beats write; held write waits out the sweep ----
        clr_req = 1; wr_req = 1; wr_addr = 2; wr_data = 16'h00FF;
        rd_en = 1; rd_addr_a = 5; rd_addr_b = 3;
        tick();
        check("clr_wr_dropped", wr_done, 0);
        check("clr_busy", busy, 1);
        check("clr_rd_preclear_a", rd_data_a, 16'h1234);
        check("clr_rd_preclear_b", rd_data_b, 16'hBEEF);
        clr_req = 0; wr_addr = 9; wr_data = 16'h0999;
        rd_addr_a = 5; rd_addr_b = 3;
        cnt = 0; wr_during_busy = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            if (wr_done) wr_during_busy++;
            clr_req = (i == 3);
            tick();
            if (i == 0) begin
                check("busy_rd_valid", rd_valid, 1);
                check("busy_rd_a_zero", rd_data_a, 0);
                check("busy_rd_b_zero", rd_data_b, 0);
                rd_en = 0;
            end
        end
        clr_req = 0;
        check("clr_busy_cycles", cnt, 16);
        check("clr_no_wr_done", wr_during_busy, 0);
        check("clr_done_pulse", clr_done, 1);
        check("clr_busy_low", busy, 0);
        tick();
        check("held_wr_done", wr_done, 1);
        check("clr_done_low", clr_done, 0);
        wr_req = 0;
        rd_en = 1; rd_addr_a = 2; rd_addr_b = 9;
        tick();
        check("addr2_cleared", rd_data_a, 0);
        check("addr9_written", rd_data_b, 16'h0999);
        rd_en = 0;

        // ---- reset in the middle of a sweep ----
        wr_req = 1; wr_addr = 15; wr_data = 16'hFFFF;
        tick();
        wr_req = 0; rd_en = 1; rd_addr_a = 15; rd_addr_b = 15;
        tick();
        check("rd15_a", rd_data_a, 16'hFFFF);
        rd_en = 0; clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 7; i++) tick();
        check("midsweep_busy", busy, 1);
        rst = 1;
        #1;
        check("midrst_rd_a", rd_data_a, 0);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_busy", busy, 1);
        tick(); tick();
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            tick();
        end
        check("restart_busy_cycles", cnt, 16);
        check("restart_clr_done", clr_done, 1);
        rd_en = 1; rd_addr_a = 15; rd_addr_b = 5;
        tick();
        check("restart_addr15", rd_data_a, 0);
        check("restart_addr5", rd_data_b, 0);
        rd_en = 0;

        // ---- wide/deep instance ----
        cnt = 0;
        while (busy_w && cnt < 100) begin
            cnt++;
            tick();
        end
        check("wide_sweep_ended", busy_w, 0);
        wr_req_w = 1; wr_addr_w = 63; wr_data_w = 32'hDEADBEEF;
        tick();
        check("wide_wr_done", wr_done_w, 1);
        wr_req_w = 0; rd_en_w = 1; rd_addr_a_w = 63; rd_addr_b_w = 0;
        tick();
        check("wide_rd_valid", rd_valid_w, 1);
        check("wide_rd_a", rd_data_a_w, 32'hDEADBEEF);
        check("wide_rd_b", rd_data_b_w, 0);
        rd_en_w = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
